mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates the instruction cache and the data cache onto a single memory
// port. Only one memory transaction is outstanding at a time. A granted
// request is latched in full, so requester inputs are ignored until the
// completion cycle. Read data lands in a shared line buffer. That buffer
// drives both cache data outputs.
//
// Parameters
//   offset_width      log2 of 32-bit words per cache line
//
// Ports
//   clk, rstn         clock and asynchronous active-low reset
//   icache_mem_req    Icache request (level, held until dataOK)
//   addr_icache_mem   Icache address (line-aligned, or word address if SUC)
//   icache_mem_SUC    Icache uncached single-word fetch
//   mem_icache_dataOK Icache completion pulse
//   din_mem_icache    returned line to Icache
//   dcache_mem_req    Dcache request (level, held until dataOK)
//   dcache_mem_we     Dcache write-through store when set
//   addr_dcache_mem   Dcache address
//   dout_dcache_mem   Dcache store data
//   dcache_mem_size   Dcache access size (0:byte 1:half 2:word)
//   dcache_mem_SUC    Dcache uncached single-word access
//   mem_dcache_dataOK Dcache completion pulse
//   din_mem_dcache    returned line to Dcache
//   arb_mem_*         registered request to memory
//   mem_arb_ack       memory accepted the request
//   mem_arb_rvalid    read beat valid, mem_arb_rdata carries the word
//   mem_arb_bvalid    write completion
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned offset_width = 2
) (
    input  logic                              clk,
    input  logic                              rstn,

    input  logic                              icache_mem_req,
    input  logic [31:0]                       addr_icache_mem,
    input  logic                              icache_mem_SUC,
    output logic                              mem_icache_dataOK,
    output logic [32*(1<<offset_width)-1:0]   din_mem_icache,

    input  logic                              dcache_mem_req,
    input  logic                              dcache_mem_we,
    input  logic [31:0]                       addr_dcache_mem,
    input  logic [31:0]                       dout_dcache_mem,
    input  logic [1:0]                        dcache_mem_size,
    input  logic                              dcache_mem_SUC,
    output logic                              mem_dcache_dataOK,
    output logic [32*(1<<offset_width)-1:0]   din_mem_dcache,

    output logic                              arb_mem_req,
    output logic [31:0]                       arb_mem_addr,
    output logic                              arb_mem_we,
    output logic [31:0]                       arb_mem_wdata,
    output logic [1:0]                        arb_mem_size,
    output logic [7:0]                        arb_mem_len,
    input  logic                              mem_arb_ack,
    input  logic                              mem_arb_rvalid,
    input  logic [31:0]                       mem_arb_rdata,
    input  logic                              mem_arb_bvalid
);

    localparam int unsigned Words  = 1 << offset_width;
    localparam int unsigned CntW   = offset_width + 1;
    localparam logic [7:0]  RefLen = 8'(Words - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIRead,
        StDRead,
        StDWrite,
        StDone
    } state_e;

    // Requester identity, used for both last_grant and the current owner.
    localparam logic GntI = 1'b0;
    localparam logic GntD = 1'b1;

    state_e                    state_q;
    logic                      last_grant_q;
    logic                      owner_q;
    logic                      suc_q;
    logic                      acked_q;
    logic [CntW-1:0]           cnt_q;
    logic [Words-1:0][31:0]    line_q;

    // Tie-break: Icache wins unless it was granted last.
    logic pick_i;
    logic pick_d;
    logic last_beat;

    always_comb begin
        pick_i    = icache_mem_req && (!dcache_mem_req || (last_grant_q == GntD));
        pick_d    = dcache_mem_req && !pick_i;
        last_beat = (cnt_q == arb_mem_len[CntW-1:0]);
    end

    assign din_mem_icache = line_q;
    assign din_mem_dcache = line_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q           <= StIdle;
            last_grant_q      <= GntD;
            owner_q           <= GntI;
            suc_q             <= 1'b0;
            acked_q           <= 1'b0;
            cnt_q             <= '0;
            line_q            <= '0;
            arb_mem_req       <= 1'b0;
            arb_mem_addr      <= '0;
            arb_mem_we        <= 1'b0;
            arb_mem_wdata     <= '0;
            arb_mem_size      <= '0;
            arb_mem_len       <= '0;
            mem_icache_dataOK <= 1'b0;
            mem_dcache_dataOK <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_i) begin
                        state_q      <= StIRead;
                        last_grant_q <= GntI;
                        owner_q      <= GntI;
                        suc_q        <= icache_mem_SUC;
                        acked_q      <= 1'b0;
                        cnt_q        <= '0;
                        arb_mem_req  <= 1'b1;
                        arb_mem_addr <= addr_icache_mem;
                        arb_mem_we   <= 1'b0;
                        arb_mem_size <= 2'd2;
                        arb_mem_len  <= icache_mem_SUC ? 8'd0 : RefLen;
                    end else if (pick_d) begin
                        state_q       <= dcache_mem_we ? StDWrite : StDRead;
                        last_grant_q  <= GntD;
                        owner_q       <= GntD;
                        suc_q         <= dcache_mem_SUC;
                        acked_q       <= 1'b0;
                        cnt_q         <= '0;
                        arb_mem_req   <= 1'b1;
                        arb_mem_addr  <= addr_dcache_mem;
                        arb_mem_we    <= dcache_mem_we;
                        arb_mem_wdata <= dout_dcache_mem;
                        // Single-word accesses carry the requester size;
                        // refills always move whole words.
                        if (dcache_mem_we || dcache_mem_SUC) begin
                            arb_mem_size <= dcache_mem_size;
                            arb_mem_len  <= 8'd0;
                        end else begin
                            arb_mem_size <= 2'd2;
                            arb_mem_len  <= RefLen;
                        end
                    end
                end

                StIRead, StDRead: begin
                    if (arb_mem_req && mem_arb_ack) begin
                        arb_mem_req <= 1'b0;
                        acked_q     <= 1'b1;
                    end
                    // Beats only count once the ack has been seen in an
                    // earlier cycle; anything before that is stray.
                    if (acked_q && mem_arb_rvalid) begin
                        if (suc_q) begin
                            line_q    <= '0;
                            line_q[0] <= mem_arb_rdata;
                        end else begin
                            for (int unsigned w = 0; w < Words; w++) begin
                                if (cnt_q == CntW'(w)) begin
                                    line_q[w] <= mem_arb_rdata;
                                end
                            end
                        end
                        if (last_beat) begin
                            cnt_q   <= '0;
                            state_q <= StDone;
                            if (owner_q == GntI) begin
                                mem_icache_dataOK <= 1'b1;
                            end else begin
                                mem_dcache_dataOK <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                StDWrite: begin
                    if (arb_mem_req && mem_arb_ack) begin
                        arb_mem_req <= 1'b0;
                        acked_q     <= 1'b1;
                    end
                    if (acked_q && mem_arb_bvalid) begin
                        state_q           <= StDone;
                        mem_dcache_dataOK <= 1'b1;
                    end
                end

                StDone: begin
                    // Completion cycle: requests are deliberately not
                    // sampled here so a held request cannot be regranted.
                    mem_icache_dataOK <= 1'b0;
                    mem_dcache_dataOK <= 1'b0;
                    acked_q           <= 1'b0;
                    state_q           <= StIdle;
                end

                default: begin
                    state_q     <= StIdle;
                    arb_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
